// File: rtl/mips_core_pkg.sv
// Shared types for the out-of-order core.
//   DATA_WIDTH : architectural result width
//   ROB_DEPTH  : default reorder-buffer entry count
//   MipsReg    : 5-bit architectural register index
//   RobTag     : reorder-buffer entry index
//   RobEntry   : one reorder-buffer slot (status bits, destination, result)
package mips_core_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);

  typedef logic [4:0]           MipsReg;
  typedef logic [ROB_TAG_W-1:0] RobTag;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  uses_rw;
    MipsReg                rw_addr;
    logic [DATA_WIDTH-1:0] data;
  } RobEntry;

endpackage

// File: rtl/rob_youngest_match.sv
// Circular priority search over the reorder-buffer entries.
// Finds the entry closest behind tail (tail-1, tail-2, ... wrapping) whose
// match bit is set, i.e. the youngest matching in-flight instruction.
//   match_vec : per-entry match bits
//   tail      : current allocation pointer
//   match_idx : index of the youngest match (0 when no hit)
//   hit       : at least one match bit set
module rob_youngest_match
  import mips_core_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_vec,
  input  logic [TAG_W-1:0] tail,
  output logic [TAG_W-1:0] match_idx,
  output logic             hit
);

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); the last
  // hit written is the youngest one.
  always_comb begin
    match_idx = '0;
    hit       = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_vec[tail - TAG_W'(k)]) begin
        match_idx = tail - TAG_W'(k);
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Allocates one tag per dispatched instruction,
// accepts out-of-order completions, retires in program order and drives the
// architectural write-back. A combinational lookup exposes completed but
// unretired results to decode-side forwarding.
//   clk, rst_n                          : clock, async active-low reset
//   i_alloc_*, o_alloc_ready/o_alloc_tag: dispatch allocation handshake
//   i_cpl_*                             : execution-unit completion
//   i_flush                             : squash every entry
//   i_lookup_addr, o_lookup_*           : forwarding query
//   o_retire_valid, o_wb_*              : registered write-back of retirement
//   o_count                             : occupied entries
module reorder_buffer
  import mips_core_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc_valid,
  input  logic              i_alloc_uses_rw,
  input  logic [4:0]        i_alloc_rw_addr,
  output logic              o_alloc_ready,
  output logic [TAG_W-1:0]  o_alloc_tag,
  input  logic              i_cpl_valid,
  input  logic [TAG_W-1:0]  i_cpl_tag,
  input  logic [DATA_W-1:0] i_cpl_data,
  input  logic              i_flush,
  input  logic [4:0]        i_lookup_addr,
  output logic              o_lookup_hit,
  output logic              o_lookup_done,
  output logic [DATA_W-1:0] o_lookup_data,
  output logic              o_retire_valid,
  output logic              o_wb_uses_rw,
  output logic [4:0]        o_wb_rw_addr,
  output logic [DATA_W-1:0] o_wb_rw_data,
  output logic [TAG_W:0]    o_count
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic [DEPTH-1:0]  ent_uses_rw;
  MipsReg            ent_rw_addr [DEPTH];
  logic [DATA_W-1:0] ent_data    [DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;

  logic              alloc_fire;
  logic              cpl_fire;
  logic              retire_fire;

  logic              vld_p1;
  logic              wb_uses_rw_p1;
  MipsReg            wb_rw_addr_p1;
  logic [DATA_W-1:0] wb_rw_data_p1;

  logic [DEPTH-1:0]  lk_match;
  logic [TAG_W-1:0]  lk_idx;
  logic              lk_hit;

  // Ready comes from the registered count only: a full buffer that retires
  // this cycle still refuses the allocation.
  assign o_alloc_ready = (count != FULL_CNT);
  assign o_alloc_tag   = tail;
  assign alloc_fire    = i_alloc_valid & o_alloc_ready;
  // An allocation reusing the completing tag wins; the completion is dropped.
  assign cpl_fire      = i_cpl_valid & ent_valid[i_cpl_tag]
                       & ~(alloc_fire & (i_cpl_tag == tail));
  assign retire_fire   = ent_valid[head] & ent_done[head];

  // Stage p0 -> p1: entry status, pointers and registered retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid     <= '0;
      ent_done      <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      vld_p1        <= 1'b0;
      wb_uses_rw_p1 <= 1'b0;
      wb_rw_addr_p1 <= '0;
      wb_rw_data_p1 <= '0;
    end else if (i_flush) begin
      ent_valid     <= '0;
      ent_done      <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      vld_p1        <= 1'b0;
      wb_uses_rw_p1 <= 1'b0;
      wb_rw_addr_p1 <= '0;
      wb_rw_data_p1 <= '0;
    end else begin
      if (cpl_fire) begin
        ent_done[i_cpl_tag] <= 1'b1;
      end
      // Retire clear is placed after the completion so it wins on the head.
      if (retire_fire) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + TAG_W'(1);
      end
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + TAG_W'(1);
      end
      count <= count + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire_fire};

      vld_p1        <= retire_fire;
      wb_uses_rw_p1 <= retire_fire & ent_uses_rw[head] & (ent_rw_addr[head] != '0);
      if (retire_fire) begin
        wb_rw_addr_p1 <= ent_rw_addr[head];
        wb_rw_data_p1 <= ent_data[head];
      end
    end
  end

  // Payload storage; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!i_flush && alloc_fire) begin
      ent_uses_rw[tail] <= i_alloc_uses_rw;
      ent_rw_addr[tail] <= i_alloc_rw_addr;
    end
    if (!i_flush && cpl_fire) begin
      ent_data[i_cpl_tag] <= i_cpl_data;
    end
  end

  always_comb begin
    lk_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_match[i] = ent_valid[i] & ent_uses_rw[i]
                  & (ent_rw_addr[i] == i_lookup_addr) & (i_lookup_addr != '0);
    end
  end

  rob_youngest_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_match (
    .match_vec (lk_match),
    .tail      (tail),
    .match_idx (lk_idx),
    .hit       (lk_hit)
  );

  assign o_lookup_hit  = lk_hit;
  assign o_lookup_done = lk_hit & ent_done[lk_idx];
  assign o_lookup_data = lk_hit ? ent_data[lk_idx] : '0;

  assign o_retire_valid = vld_p1;
  assign o_wb_uses_rw   = wb_uses_rw_p1;
  assign o_wb_rw_addr   = wb_rw_addr_p1;
  assign o_wb_rw_data   = wb_rw_data_p1;
  assign o_count        = count;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the out-of-order core. It allocates a tag per dispatched instruction, accepts out-of-order completions from the execution units, and retires results in program order.
- Retired results are driven as the architectural write-back (uses_rw / rw_addr / rw_data) to the register file and to every forwarding consumer.
- A combinational lookup port lets the decode-side forwarding logic source values from completed-but-unretired entries.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2, ≥2.
- TAG_W, $clog2(DEPTH), tag width.
- DATA_W, `DATA_WIDTH (32), result width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_alloc_valid  in  1  dispatch requests an entry.
- i_alloc_uses_rw  in  1  instruction writes a register.
- i_alloc_rw_addr  in  5  destination register (MipsReg).
- o_alloc_ready  out  1  entry available.
- o_alloc_tag  out  TAG_W  tag assigned on an allocation handshake (= tail).
- i_cpl_valid  in  1  execution unit completion.
- i_cpl_tag  in  TAG_W  completing entry.
- i_cpl_data  in  DATA_W  result.
- i_flush  in  1  squash all entries (mispredict).
- i_lookup_addr  in  5  register queried by forwarding.
- o_lookup_hit  out  1  an in-flight entry will write i_lookup_addr.
- o_lookup_done  out  1  the matching entry has its result.
- o_lookup_data  out  DATA_W  result of the matching entry.
- o_retire_valid  out  1  one entry retired.
- o_wb_uses_rw  out  1  write-back enable.
- o_wb_rw_addr  out  5  write-back register.
- o_wb_rw_data  out  DATA_W  write-back data.
- o_count  out  TAG_W+1  occupied entries.

Behaviour:
- Reset (async, rst_n=0):
  - head=tail=0, count=0, all entry valid/done bits cleared.
  - o_retire_valid, o_wb_uses_rw, o_wb_rw_addr, o_wb_rw_data all 0.
  - Reset mid-operation discards everything; no partial retire is emitted.
- Allocation:
  - Fires on i_alloc_valid & o_alloc_ready.
  - o_alloc_ready = (count != DEPTH), decoded from registered count only. There is no same-cycle retire bypass, so a full buffer stays not-ready during a retire cycle.
  - On allocation the entry is written valid=1, done=0 with uses_rw and rw_addr; tail increments mod DEPTH.
- Completion:
  - On i_cpl_valid, the entry at i_cpl_tag is written data and done=1.
  - A completion to an invalid entry is ignored (no state change).
  - A completion and an allocation to the same tag in the same cycle: the allocation wins and the completion is dropped.
- Retire:
  - At most one entry per cycle, when the head entry has valid & done.
  - On the edge: the entry is cleared, head increments, and the outputs are registered. o_retire_valid=1; o_wb_uses_rw = uses_rw & (rw_addr != 0); o_wb_rw_addr and o_wb_rw_data come from the entry.
  - With no retire, o_retire_valid=0 and o_wb_uses_rw=0; addr/data hold their last value.
  - Latency: completion sampled at edge k → head done visible after k → o_retire_valid high after edge k+1 (minimum 2 edges).
- Count:
  - count += alloc_fire − retire_fire.
  - Simultaneous alloc and retire leaves count unchanged.
  - Head/tail wrap mod DEPTH; full vs empty is disambiguated by count only.
- Flush (synchronous, highest priority after reset):
  - Clears all valid/done bits; head=tail=count=0.
  - Any allocation, completion or retire in the flush cycle is suppressed; outputs are 0 after the edge.
- Lookup (combinational):
  - Returns the youngest valid entry with uses_rw & rw_addr == i_lookup_addr & i_lookup_addr != 0, searching from tail−1 back to head.
  - With no match: hit=0, done=0, data=0.
  - An entry retiring this cycle is still visible to lookup.

Decomposition:
- mips_core_pkg gets: ROB_DEPTH constant, RobTag typedef (logic [TAG_W-1:0]), and a RobEntry struct {valid, done, uses_rw, MipsReg rw_addr, data}.
- Sub-module rob_youngest_match: parameterised circular priority search of DEPTH entries relative to tail. Outputs match index and hit; it is purely combinational.

Test Plan:
- Reset, then 3 allocs (r5, r6, r7) → tags 0,1,2, count=3. Complete tag1=0x11, then tag0=0xA → retire r5=0xA, then r6=0x11 on consecutive cycles; r7 stays pending.
- Fill all 8 entries → o_alloc_ready=0. Complete head and retire while alloc_valid=1 → no alloc that cycle; ready returns next cycle. Tail wraps to 0; the next tag issued is 0 after 8 allocs.
- Two in-flight writers of r3 (tag2 done 0x22, tag4 not done) → lookup r3 gives hit=1, done=0 (youngest). Complete tag4=0x44 → done=1, data=0x44. Lookup r0 → hit=0.
- Alloc with rw_addr=0, uses_rw=1, complete 0xFF → retire with o_retire_valid=1, o_wb_uses_rw=0.
- 5 entries in flight, head done, assert i_flush with simultaneous alloc and cpl → after the edge: count=0, o_retire_valid=0, next alloc tag=0; a later completion to old tag3 is ignored.
- Drop rst_n asynchronously mid-cycle while o_retire_valid=1 → outputs go to 0 immediately, with no edge required.
